pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised next-generation program counter for the RISC-V fetch stage.
- Selects next PC by fixed priority: trap vector, resolved branch/jump redirect, return-address-stack (RAS) predicted return, sequential step.
- Supports optional compressed (2-byte) stepping, hold/stall, and target alignment checking.
- Contains a small circular RAS that execute pushes to and fetch pops from.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VEC, 0, PC value loaded on reset; must be 4-byte aligned.
- RAS_DEPTH, 4, number of RAS entries; power of 2, at least 2.
- C_EXT, 0, 1 enables 2-byte instruction stepping and 2-byte target alignment.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  stall; freezes the sequential step and RAS predicted-return path.
- trap_valid  in  1  take trap this cycle.
- trap_vec  in  XLEN  trap handler address.
- redirect_valid  in  1  resolved branch/jump target valid.
- redirect_pc  in  XLEN  branch/jump target.
- inst_len16  in  1  current instruction is 16-bit; honoured only when C_EXT=1.
- pred_ret  in  1  fetch predicts a return; request RAS pop.
- ras_push  in  1  execute retires a call; push push_addr.
- push_addr  in  XLEN  return address to push.
- pc  out  XLEN  current PC (registered).
- misalign_err  out  1  one-cycle pulse: previous redirect target was misaligned.
- ras_top  out  XLEN  entry at top of stack; 0 when empty.
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_VEC, misalign_err=0.
  - RAS count=0, pointer=0, all entries=0.
  - ras_empty=1, ras_full=0, ras_top=0.
- Next-PC priority, evaluated each edge:
  - 1. trap_valid: pc <= trap_vec with bits[1:0] forced to 0. Ignores hold. RAS is cleared (count=0); a same-cycle ras_push is discarded.
  - 2. redirect_valid: pc <= redirect_pc with bit0 cleared, and bit1 also cleared when C_EXT=0. Ignores hold. Any same-cycle pred_ret pop is suppressed.
  - 3. hold=1: pc unchanged; pred_ret ignored.
  - 4. pred_ret=1 and RAS not empty: pc <= ras_top; RAS pops.
  - 5. pred_ret=1 and RAS empty: treated as no prediction; fall through to 6.
  - 6. Sequential step: pc <= pc+2 when C_EXT=1 and inst_len16=1, else pc+4.
- Arithmetic is modulo 2^XLEN: from all-ones-minus-3, pc wraps to 0; no flag is raised.
- misalign_err:
  - Registered; equals 1 for exactly the cycle after an accepted redirect (priority 2) where redirect_pc[1]=1 and C_EXT=0.
  - 0 in all other cases, including traps.
- RAS is a circular buffer; the top pointer indexes the most recent entry.
  - Push only (ras_push, no effective pop): pointer advances and push_addr is written.
  - Push when full: overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop only: pointer retreats; count decrements.
  - Pop when empty: never happens (gated by priority 5).
  - Push and effective pop in the same cycle: top entry is replaced by push_addr; count and pointer unchanged.
  - ras_push is independent of hold and redirect; it is blocked only by trap.
  - ras_top, ras_empty and ras_full are derived from registered state, so they reflect pushes and pops the cycle after they occur.

Test Plan:
1. Reset and step: XLEN=32, RESET_VEC=0x100, C_EXT=0. Assert rst, then release; run 3 cycles idle -> pc 0x100, 0x104, 0x108, 0x10C. Assert rst mid-cycle -> pc=0x100 immediately, without waiting for a clock edge.
2. Priority: trap_valid=1, trap_vec=0x203, redirect_valid=1 and hold=1 in the same cycle -> pc=0x200 and RAS empty. Next cycle redirect_valid=1, redirect_pc=0x402, hold=1 -> pc=0x400 and misalign_err=1 for one cycle.
3. Hold: pc=0x40, hold=1 for 3 cycles with pred_ret=1 and a non-empty RAS -> pc stays 0x40 and RAS count is unchanged.
4. RAS: RAS_DEPTH=4. Push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 -> ras_full=1 and ras_top=0xE0. Then pred_ret 4 times -> pc sequence 0xE0, 0xD0, 0xC0, 0xB0, after which ras_empty=1. A fifth pred_ret -> pc = pc+4.
5. Simultaneous operations: RAS holds [0x10, 0x20]; pred_ret with ras_push of 0x30 -> pc=0x20, ras_top=0x30, count=2. Then redirect_valid with pred_ret -> pc=redirect target and ras_top stays 0x30.
6. Compressed and wrap: C_EXT=1, pc=0xFFFFFFFC, inst_len16=1 -> pc=0xFFFFFFFE; next inst_len16=1 -> pc=0x0. redirect_pc=0x1002 -> pc=0x1002 and misalign_err=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter for the fetch stage.
//
// The next PC is chosen by fixed priority: trap vector, resolved redirect,
// hold, RAS-predicted return, then the sequential step (+2 for a compressed
// instruction when C_EXT=1, otherwise +4). A small circular return-address
// stack (RAS) is pushed by execute on retired calls and popped by fetch on
// predicted returns.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            asynchronous active-high reset
//   hold_i           stall: freezes the sequential step and the RAS pop path
//   trap_valid_i     take a trap this cycle
//   trap_vec_i       trap handler address (forced to 4-byte alignment)
//   redirect_valid_i resolved branch/jump target valid
//   redirect_pc_i    branch/jump target
//   inst_len16_i     current instruction is 16-bit (used only when C_EXT=1)
//   pred_ret_i       fetch predicts a return; requests a RAS pop
//   ras_push_i       execute retires a call; push push_addr_i
//   push_addr_i      return address to push
//   pc_o             current PC (registered)
//   misalign_err_o   one-cycle pulse after a misaligned redirect target
//   ras_top_o        most recent RAS entry, 0 when empty
//   ras_empty_o      RAS holds no entries
//   ras_full_o       RAS holds RAS_DEPTH entries

module pc_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter int unsigned     C_EXT     = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hold_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            inst_len16_i,
    input  logic            pred_ret_i,
    input  logic            ras_push_i,
    input  logic [XLEN-1:0] push_addr_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_err_o,
    output logic [XLEN-1:0] ras_top_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);

    localparam bit          CExt = (C_EXT != 0);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];

    logic            pop_en;
    logic            push_en;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] redirect_mask;

    assign ras_empty_o    = (cnt_q == '0);
    assign ras_full_o     = (cnt_q == CntW'(RAS_DEPTH));
    assign ras_top_o      = ras_empty_o ? '0 : ras_q[ptr_q];
    assign pc_o           = pc_q;
    assign misalign_err_o = misalign_q;

    always_comb begin
        // A pop only happens when the prediction path actually wins.
        pop_en        = pred_ret_i && !ras_empty_o && !hold_i &&
                        !redirect_valid_i && !trap_valid_i;
        push_en       = ras_push_i && !trap_valid_i;
        step          = (CExt && inst_len16_i) ? XLEN'(2) : XLEN'(4);
        redirect_mask = CExt ? ~XLEN'(1) : ~XLEN'(3);

        // Next PC by priority.
        if (trap_valid_i) begin
            pc_d = trap_vec_i & ~XLEN'(3);
        end else if (redirect_valid_i) begin
            pc_d = redirect_pc_i & redirect_mask;
        end else if (hold_i) begin
            pc_d = pc_q;
        end else if (pop_en) begin
            pc_d = ras_q[ptr_q];
        end else begin
            pc_d = pc_q + step;
        end

        misalign_d = !trap_valid_i && redirect_valid_i && redirect_pc_i[1] && !CExt;

        // RAS next state.
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (trap_valid_i) begin
            cnt_d = '0;
        end else if (push_en && pop_en) begin
            // Pop and push cancel: replace the top in place.
            ras_d[ptr_q] = push_addr_i;
        end else if (push_en) begin
            // When full, the advanced pointer lands on the oldest entry.
            ptr_d        = ptr_q + PtrW'(1);
            ras_d[ptr_d] = push_addr_i;
            if (!ras_full_o) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop_en) begin
            ptr_d = ptr_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Two instances share all stimulus: u_dut
// (C_EXT=0) carries most checks, u_dut_c (C_EXT=1) covers compressed stepping
// and 2-byte redirect alignment. Expected values are queued as stimulus is
// applied and compared after the following clock edge.

module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_len16 = 1'b0;
    logic        pred_ret = 1'b0;
    logic        ras_push = 1'b0;
    logic [31:0] push_addr = '0;

    logic [31:0] pc, pc_c, ras_top, ras_top_c;
    logic        misalign, misalign_c, ras_empty, ras_empty_c, ras_full, ras_full_c;

    pc_fetch_unit #(
        .XLEN(32), .RESET_VEC(32'h100), .RAS_DEPTH(4), .C_EXT(0)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .trap_valid_i(trap_valid),
        .trap_vec_i(trap_vec), .redirect_valid_i(redirect_valid),
        .redirect_pc_i(redirect_pc), .inst_len16_i(inst_len16), .pred_ret_i(pred_ret),
        .ras_push_i(ras_push), .push_addr_i(push_addr), .pc_o(pc),
        .misalign_err_o(misalign), .ras_top_o(ras_top), .ras_empty_o(ras_empty),
        .ras_full_o(ras_full)
    );

    pc_fetch_unit #(
        .XLEN(32), .RESET_VEC(32'h100), .RAS_DEPTH(4), .C_EXT(1)
    ) u_dut_c (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .trap_valid_i(trap_valid),
        .trap_vec_i(trap_vec), .redirect_valid_i(redirect_valid),
        .redirect_pc_i(redirect_pc), .inst_len16_i(inst_len16), .pred_ret_i(pred_ret),
        .ras_push_i(ras_push), .push_addr_i(push_addr), .pc_o(pc_c),
        .misalign_err_o(misalign_c), .ras_top_o(ras_top_c), .ras_empty_o(ras_empty_c),
        .ras_full_o(ras_full_c)
    );

    always #5 clk = ~clk;

    // Observed signal selectors.
    localparam int SelPc = 0, SelMis = 1, SelTop = 2, SelEmpty = 3, SelFull = 4;
    localparam int SelPcC = 5, SelMisC = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SelPc:    return pc;
            SelMis:   return {31'b0, misalign};
            SelTop:   return ras_top;
            SelEmpty: return {31'b0, ras_empty};
            SelFull:  return {31'b0, ras_full};
            SelPcC:   return pc_c;
            SelMisC:  return {31'b0, misalign_c};
            default:  return 'x;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance one edge, then compare away from it.
    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic idle();
        hold = 0; trap_valid = 0; redirect_valid = 0; inst_len16 = 0;
        pred_ret = 0; ras_push = 0;
    endtask

    initial begin
        // 1. Reset and sequential step.
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        expect_val("rst_pc", SelPc, 32'h100);
        expect_val("rst_mis", SelMis, 0);
        expect_val("rst_empty", SelEmpty, 1);
        expect_val("rst_full", SelFull, 0);
        expect_val("rst_top", SelTop, 0);
        check_now();
        expect_val("step1", SelPc, 32'h104); tick();
        expect_val("step2", SelPc, 32'h108); tick();
        expect_val("step3", SelPc, 32'h10C); tick();
        #2 rst = 1'b1;
        #1 expect_val("async_rst", SelPc, 32'h100);
        check_now();
        rst = 1'b0;

        // 2. Priority: trap beats redirect/hold and clears the RAS.
        ras_push = 1; push_addr = 32'h77;
        expect_val("pre_push_top", SelTop, 32'h77); tick();
        trap_valid = 1; trap_vec = 32'h203; redirect_valid = 1; redirect_pc = 32'h402;
        hold = 1; push_addr = 32'h55;
        expect_val("trap_pc", SelPc, 32'h200);
        expect_val("trap_empty", SelEmpty, 1);
        expect_val("trap_top", SelTop, 0);
        expect_val("trap_mis", SelMis, 0);
        tick();
        trap_valid = 0; ras_push = 0;
        expect_val("redir_pc", SelPc, 32'h400);
        expect_val("redir_mis", SelMis, 1);
        expect_val("redir_pc_c", SelPcC, 32'h402);
        expect_val("redir_mis_c", SelMisC, 0);
        tick();
        idle();
        expect_val("mis_pulse_end", SelMis, 0);
        expect_val("after_redir_pc", SelPc, 32'h404);
        tick();

        // 3. Hold freezes PC and suppresses pops.
        redirect_valid = 1; redirect_pc = 32'h40; ras_push = 1; push_addr = 32'h90;
        expect_val("hold_setup_pc", SelPc, 32'h40);
        expect_val("hold_setup_top", SelTop, 32'h90);
        tick();
        idle();
        hold = 1; pred_ret = 1;
        for (int i = 0; i < 3; i++) begin
            expect_val("hold_pc", SelPc, 32'h40);
            expect_val("hold_top", SelTop, 32'h90);
            tick();
        end
        hold = 0;
        expect_val("unhold_pop_pc", SelPc, 32'h90);
        expect_val("unhold_empty", SelEmpty, 1);
        tick();
        idle();

        // 4. RAS fill, overwrite-oldest, drain, empty fall-through.
        ras_push = 1;
        push_addr = 32'hA0; tick();
        push_addr = 32'hB0; tick();
        push_addr = 32'hC0;
        expect_val("fill3_full", SelFull, 0); tick();
        push_addr = 32'hD0;
        expect_val("fill4_full", SelFull, 1);
        expect_val("fill4_top", SelTop, 32'hD0); tick();
        push_addr = 32'hE0;
        expect_val("fill5_full", SelFull, 1);
        expect_val("fill5_top", SelTop, 32'hE0); tick();
        idle();
        pred_ret = 1;
        expect_val("pop1_pc", SelPc, 32'hE0); tick();
        expect_val("pop2_pc", SelPc, 32'hD0); tick();
        expect_val("pop3_pc", SelPc, 32'hC0);
        expect_val("pop3_top", SelTop, 32'hB0); tick();
        expect_val("pop4_pc", SelPc, 32'hB0);
        expect_val("pop4_empty", SelEmpty, 1); tick();
        expect_val("pop_empty_pc", SelPc, 32'hB4); tick();
        idle();

        // 5. Simultaneous push/pop, and redirect suppressing a pop.
        ras_push = 1;
        push_addr = 32'h10; tick();
        push_addr = 32'h20; tick();
        pred_ret = 1; push_addr = 32'h30;
        expect_val("pushpop_pc", SelPc, 32'h20);
        expect_val("pushpop_top", SelTop, 32'h30);
        tick();
        ras_push = 0; redirect_valid = 1; redirect_pc = 32'h600;
        expect_val("redir_nopop_pc", SelPc, 32'h600);
        expect_val("redir_nopop_top", SelTop, 32'h30);
        tick();
        redirect_valid = 0;
        expect_val("cnt2_pop1", SelPc, 32'h30); tick();
        expect_val("cnt2_pop2", SelPc, 32'h10);
        expect_val("cnt2_empty", SelEmpty, 1); tick();
        idle();

        // 6. Compressed stepping and wrap.
        trap_valid = 1; trap_vec = 32'hFFFF_FFFC;
        expect_val("wrap_setup", SelPc, 32'hFFFF_FFFC);
        expect_val("wrap_setup_c", SelPcC, 32'hFFFF_FFFC);
        tick();
        trap_valid = 0; inst_len16 = 1;
        expect_val("c16_step1", SelPcC, 32'hFFFF_FFFE);
        expect_val("wrap_pc", SelPc, 32'h0);
        tick();
        expect_val("c16_wrap", SelPcC, 32'h0);
        expect_val("nc_ignore16", SelPc, 32'h4);
        tick();
        inst_len16 = 0; redirect_valid = 1; redirect_pc = 32'h1002;
        expect_val("c_redir_pc", SelPcC, 32'h1002);
        expect_val("c_redir_mis", SelMisC, 0);
        expect_val("nc_redir_pc", SelPc, 32'h1000);
        expect_val("nc_redir_mis", SelMis, 1);
        tick();
        idle();
        expect_val("nc_mis_clear", SelMis, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
